// File: rtl/alu_issue.sv
// alu_issue: single-request issue/response sequencer in front of a combinational ALU.
//
// A request word {opcode, a, b} is accepted in idle. A legal opcode is presented to the
// ALU on op/a/b for exactly ALU_LAT cycles, after which alu_result is captured and
// offered as a response. The illegal opcode 3'b111 skips the ALU and responds at once
// with out_err set and a zero result. Responses wait for out_ready; op_cnt counts
// completed responses and saturates.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake
//   in_instr              [2W+2:2W] opcode, [2W-1:W] operand a, [W-1:0] operand b
//   op, a, b              ALU control and operands (op is 3'b111 outside issue)
//   alu_result            combinational ALU output for the current op/a/b
//   out_valid/out_ready   response handshake
//   out_result, out_err   captured result, illegal-opcode flag
//   op_cnt                saturating count of completed responses
module alu_issue #(
  parameter int unsigned W       = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W+2:0]   in_instr,
  output logic [2:0]       op,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  input  logic [W-1:0]     alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_err,
  output logic [15:0]      op_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [2:0] OpNone   = 3'b111;
  localparam logic [3:0] WaitLoad = 4'(ALU_LAT - 1);

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [3:0]     wait_q, wait_d;
  logic [W-1:0]   res_q, res_d;
  logic           err_q, err_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [2:0]     req_op;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;

  assign req_op = in_instr[2*W+2:2*W];
  assign req_a  = in_instr[2*W-1:W];
  assign req_b  = in_instr[W-1:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    wait_d  = wait_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (req_op == OpNone) begin
            // Illegal opcode: no ALU pass, respond next cycle; a/b keep their old values.
            state_d = StResp;
            err_d   = 1'b1;
            res_d   = '0;
          end else begin
            state_d = StIssue;
            op_d    = req_op;
            a_d     = req_a;
            b_d     = req_b;
            wait_d  = WaitLoad;
          end
        end
      end
      StIssue: begin
        if (wait_q == 4'd0) begin
          res_d   = alu_result;
          err_d   = 1'b0;
          op_d    = OpNone;
          state_d = StResp;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StResp: begin
        if (out_ready) begin
          state_d = StIdle;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      a_q     <= '0;
      b_q     <= '0;
      wait_q  <= 4'd0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wait_q  <= wait_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StResp);
  assign op         = op_q;
  assign a          = a_q;
  assign b          = b_q;
  assign out_result = res_q;
  assign out_err    = err_q;
  assign op_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (ALU_LAT=1 and ALU_LAT=3), each with its own
// stimulus, a request-level reference model and a per-cycle compare process, plus
// directed literal checks.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [2];
  logic [18:0] instr [2];
  logic        out_ready [2];
  logic        in_ready [2];
  logic [2:0]  op [2];
  logic [7:0]  a_o [2];
  logic [7:0]  b_o [2];
  logic        out_valid [2];
  logic [7:0]  out_result [2];
  logic        out_err [2];
  logic [15:0] op_cnt [2];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [2:0] f, input logic [7:0] x,
                                        input logic [7:0] y);
    logic signed [7:0] sx;
    sx = x;
    case (f)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return 8'(sx >>> y);
      3'd3:    return x >> y;
      3'd4:    return x << y;
      3'd5:    return x & y;
      3'd6:    return x | y;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  for (genvar i = 0; i < 2; i++) begin : g
    localparam int LAT = (i == 0) ? 1 : 3;

    logic [7:0] alu_res;
    assign alu_res = alu_fn(op[i], a_o[i], b_o[i]);

    alu_issue #(.W(8), .ALU_LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[i]),
      .in_ready   (in_ready[i]),
      .in_instr   (instr[i]),
      .op         (op[i]),
      .a          (a_o[i]),
      .b          (b_o[i]),
      .alu_result (alu_res),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready[i]),
      .out_result (out_result[i]),
      .out_err    (out_err[i]),
      .op_cnt     (op_cnt[i])
    );

    // Request-level model: one outstanding request, phase = cycles since acceptance.
    bit          m_busy = 1'b0;
    bit          m_legal = 1'b0;
    int          m_k = 0;
    logic [2:0]  m_op = 3'd7;
    logic [7:0]  m_a = 8'h00;
    logic [7:0]  m_b = 8'h00;
    logic [7:0]  m_la = 8'h00;
    logic [7:0]  m_lb = 8'h00;
    logic [15:0] m_cnt = 16'h0000;
    logic        issue, resp;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy = 1'b0;
        m_cnt  = 16'h0000;
        m_la   = 8'h00;
        m_lb   = 8'h00;
      end else if (!m_busy) begin
        if (in_valid[i]) begin
          m_busy  = 1'b1;
          m_k     = 0;
          m_op    = instr[i][18:16];
          m_a     = instr[i][15:8];
          m_b     = instr[i][7:0];
          m_legal = (m_op != 3'd7);
          if (m_legal) begin
            m_la = m_a;
            m_lb = m_b;
          end
        end
      end else if (m_legal && m_k < LAT) begin
        m_k++;
      end else if (out_ready[i]) begin
        m_busy = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        issue = m_busy && m_legal && (m_k < LAT);
        resp  = m_busy && !issue;
        chk("in_ready", i, 32'(in_ready[i]), 32'(!m_busy));
        chk("op", i, 32'(op[i]), issue ? 32'(m_op) : 32'h7);
        chk("a", i, 32'(a_o[i]), 32'(m_la));
        chk("b", i, 32'(b_o[i]), 32'(m_lb));
        chk("out_valid", i, 32'(out_valid[i]), 32'(resp));
        chk("op_cnt", i, 32'(op_cnt[i]), 32'(m_cnt));
        if (resp) begin
          chk("out_result", i, 32'(out_result[i]),
              m_legal ? 32'(alu_fn(m_op, m_a, m_b)) : 32'h0);
          chk("out_err", i, 32'(out_err[i]), 32'(!m_legal));
        end
      end
    end
  end

  task automatic wait_idle(input int i);
    int n = 0;
    while (!in_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", i, 32'(in_ready[i]), 32'h1);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input int i, input logic [2:0] f, input logic [7:0] x,
                      input logic [7:0] y);
    wait_idle(i);
    in_valid[i] = 1'b1;
    instr[i]    = {f, x, y};
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_op;
    int k;
    int guard;
    logic rdy;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      instr[i]     = 19'h0;
      out_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 0, 32'(in_ready[0]), 32'h1);
    chk("rst_op", 1, 32'(op[1]), 32'h7);
    chk("rst_valid", 0, 32'(out_valid[0]), 32'h0);
    chk("rst_cnt", 1, 32'(op_cnt[1]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 5+3, latency 1
    out_ready[0] = 1'b1;
    send(0, 3'd0, 8'h05, 8'h03);
    chk("add_op", 0, 32'(op[0]), 32'h0);
    chk("add_valid_early", 0, 32'(out_valid[0]), 32'h0);
    @(negedge clk);
    chk("add_valid", 0, 32'(out_valid[0]), 32'h1);
    chk("add_result", 0, 32'(out_result[0]), 32'h08);
    chk("add_err", 0, 32'(out_err[0]), 32'h0);
    chk("add_op_after", 0, 32'(op[0]), 32'h7);
    @(negedge clk);
    chk("add_cnt", 0, 32'(op_cnt[0]), 32'h1);

    // Illegal opcode
    send(0, 3'd7, 8'hFF, 8'h00);
    chk("ill_op", 0, 32'(op[0]), 32'h7);
    chk("ill_valid", 0, 32'(out_valid[0]), 32'h1);
    chk("ill_err", 0, 32'(out_err[0]), 32'h1);
    chk("ill_result", 0, 32'(out_result[0]), 32'h00);
    @(negedge clk);
    chk("ill_cnt", 0, 32'(op_cnt[0]), 32'h2);

    // SRA with latency 3 and a 5-cycle stall
    out_ready[1] = 1'b0;
    send(1, 3'd2, 8'h80, 8'h01);
    n_op = 0;
    for (int c = 0; c < 8; c++) begin
      if (op[1] == 3'd2) n_op++;
      if (c >= 3) begin
        chk("sra_hold_res", 1, 32'(out_result[1]), 32'hC0);
        chk("sra_in_ready", 1, 32'(in_ready[1]), 32'h0);
      end
      @(negedge clk);
    end
    chk("sra_op_cycles", 1, 32'(n_op), 32'h3);
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("sra_cnt", 1, 32'(op_cnt[1]), 32'h1);

    // Reset during ISSUE of SUB
    send(1, 3'd1, 8'h09, 8'h04);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 1, 32'(out_valid[1]), 32'h0);
    chk("rst_mid_op", 1, 32'(op[1]), 32'h7);
    chk("rst_mid_cnt", 1, 32'(op_cnt[1]), 32'h0);
    chk("rst_mid_ready", 1, 32'(in_ready[1]), 32'h1);
    chk("rst_mid_a", 1, 32'(a_o[1]), 32'h0);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_resp", 1, 32'(out_valid[1]), 32'h0);
    end
    send(1, 3'd0, 8'h10, 8'h22);
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 1, 32'(out_valid[1]), 32'h1);
    chk("post_rst_result", 1, 32'(out_result[1]), 32'h32);
    @(negedge clk);
    chk("post_rst_cnt", 1, 32'(op_cnt[1]), 32'h1);

    // Back-to-back: opcodes 0..6 with in_valid held high
    out_ready[0] = 1'b1;
    wait_idle(0);
    in_valid[0] = 1'b1;
    instr[0]    = {3'd0, 8'h30, 8'h01};
    k = 0;
    guard = 0;
    while (k < 7 && guard < 200) begin
      rdy = in_ready[0];
      @(negedge clk);
      guard++;
      if (rdy) begin
        k++;
        if (k < 7) instr[0] = {3'(k), 8'(8'h30 + k), 8'(k + 1)};
        else in_valid[0] = 1'b0;
      end
    end
    chk("b2b_accepts", 0, 32'(k), 32'h7);
    wait_idle(0);
    chk("b2b_cnt", 0, 32'(op_cnt[0]), 32'h7);

    // Saturation of op_cnt
    g[0].dut.cnt_q = 16'hFFFD;
    g[0].m_cnt     = 16'hFFFD;
    repeat (4) begin
      send(0, 3'd7, 8'h00, 8'h00);
      @(negedge clk);
    end
    wait_idle(0);
    chk("sat_cnt", 0, 32'(op_cnt[0]), 32'hFFFF);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
